dual_fetch_controller: RTL and testbench
========================================

Name: dual_fetch_controller

Overview:
- Sequences the dual-word instruction memory for the superscalar front end.
- Holds the fetch PC and issues one 8-byte-aligned pair address per cycle.
- Buffers the returned instructions (with their PCs) in a small in-order queue and presents the oldest two to decode.
- Handles branch/jump redirects, including targets that are not pair-aligned, plus flushes, decode back-pressure and address wrap-around.

Parameters:
- QDEPTH, 4: queue entries (instruction + PC each); power of two, ≥4.
- IMEM_WORDS, 128: instruction memory size in words; fetch address wraps modulo IMEM_WORDS*4.
- RESET_PC, 32'h00000000: fetch PC after reset; must be a multiple of 8.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_addr  output  32  pair fetch address to instruction memory; always a multiple of 8.
- imem_instr1  input  32  word at imem_addr (combinational memory read).
- imem_instr2  input  32  word at imem_addr+4.
- redirect_valid  input  1  branch/jump taken; flush and refetch.
- redirect_target  input  32  redirect byte address; bits[1:0] ignored.
- deq_count  input  2  instructions consumed by decode this cycle (0, 1 or 2).
- out_valid0  output  1  head entry valid.
- out_instr0  output  32  head instruction.
- out_pc0  output  32  head PC.
- out_valid1  output  1  second entry valid.
- out_instr1  output  32  second instruction.
- out_pc1  output  32  second PC.
- q_count  output  3  current queue occupancy (0..QDEPTH).

Behaviour:
- Reset (async, rst_n=0): fpc=RESET_PC, skip_first=0, head=tail=0, count=0. All out_valid*=0; out_instr*/out_pc*=0; imem_addr=RESET_PC. Reset asserted mid-operation discards everything immediately; the first fetch after release uses RESET_PC.
- imem_addr = fpc, combinational. Memory data is valid in the same cycle.
- Outputs are combinational from the queue head:
  - out_valid0 = (count≥1); out_valid1 = (count≥2).
  - Any invalid slot drives instr=0 (nop) and pc=0.
- Dequeue: effective deq = min(deq_count, count). deq_count=3 is treated as 2. Over-request never underflows. head advances by the effective deq.
- Fetch-enqueue: n = 2 − skip_first words are written.
  - The enqueue happens only if (QDEPTH − count + deq) ≥ n, i.e. space freed by a same-cycle dequeue counts.
  - When it happens:
    - Words are written at tail in order: imem_instr1 with PC=fpc (skipped if skip_first), then imem_instr2 with PC=fpc+4.
    - tail and count are updated.
    - fpc ← (fpc+8) mod (IMEM_WORDS*4).
    - skip_first ← 0.
  - Otherwise: fpc and skip_first hold, and no partial pair is ever written.
- Redirect (highest priority): when redirect_valid=1 at an edge:
  - Queue flushed (count←0, head←tail) and dequeue and enqueue are ignored that cycle.
  - fpc ← {redirect_target[31:3],3'b000} mod range; skip_first ← redirect_target[2].
  - The first enqueue occurs on the next edge.
  - Outputs show the pre-flush contents during the redirect cycle; decode must qualify them with redirect itself.
- Pointers wrap modulo QDEPTH. count never exceeds QDEPTH and never goes below 0.
- Latency:
  - Empty queue, no stall: an instruction is visible on out_* one cycle after its pair address is presented.
  - After a redirect: the target is visible two edges after the redirect edge.
- Steady state with deq_count=2 every cycle: 2 instructions/cycle throughput with no bubbles.

Test Plan:
- Reset then run with deq_count=0: cycle 1 queue holds PC 0x0/0x4. Cycle 2 holds 0x0–0xC, count=4, imem_addr=0x10, and fpc stalls at 0x10 while the queue is full.
- deq_count=2 every cycle from reset: out_pc0 = 0x0, 0x8, 0x10, … each cycle, out_valid0/1=1 after the first edge, count stays 2.
- Full queue (count=4), deq_count=1 for one cycle: no enqueue (free=1<2), count=3, then next cycle with deq=1 enqueues the pair, count=4.
- Redirect to 0x2C while the queue is full and deq_count=2: queue flushed, next edge enqueues only word 11 (out_pc0=0x2C, out_valid1=0), then fetch continues at 0x30.
- Redirect to 0x28 (pair-aligned, word 10): out_pc0=0x28, out_pc1=0x2C two edges later, imem_addr=0x30.
- Wrap: redirect to 0x1F8 with deq_count=2: fetch 0x1F8/0x1FC, then imem_addr=0x000. Assert rst_n low mid-run: outputs clear immediately, imem_addr=RESET_PC.

Source files
------------

// File: rtl/dual_fetch_controller.sv
// Dual-word instruction fetch controller.
// Holds the fetch PC, issues 8-byte-aligned pair addresses, buffers the
// returned words with their PCs in an in-order queue, and presents the oldest
// two entries to decode. Redirects flush the queue and can start mid-pair.
module dual_fetch_controller #(
   parameter int unsigned QDEPTH     = 4,
   parameter int unsigned IMEM_WORDS = 128,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic                           clk,
   input  logic                           rst_n,
   output logic [31:0]                    imem_addr,
   input  logic [31:0]                    imem_instr1,
   input  logic [31:0]                    imem_instr2,
   input  logic                           redirect_valid,
   input  logic [31:0]                    redirect_target,
   input  logic [1:0]                     deq_count,
   output logic                           out_valid0,
   output logic [31:0]                    out_instr0,
   output logic [31:0]                    out_pc0,
   output logic                           out_valid1,
   output logic [31:0]                    out_instr1,
   output logic [31:0]                    out_pc1,
   output logic [$clog2(QDEPTH+1)-1:0]    q_count
);

   localparam int unsigned PW = $clog2(QDEPTH);
   localparam int unsigned CW = $clog2(QDEPTH + 1);
   localparam logic [CW:0]   L_QDEPTH = QDEPTH[CW:0];
   localparam logic [31:0]   L_RANGE  = IMEM_WORDS * 4;
   localparam logic [PW-1:0] L_ONE    = PW'(1);
   localparam logic [PW-1:0] L_TWO    = PW'(2);

   logic [31:0]   r_instr [QDEPTH];
   logic [31:0]   r_pc    [QDEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic [31:0]   r_fpc;
   logic          r_skip;

   logic [1:0]    w_deq_req;
   logic [CW-1:0] w_deq;
   logic [1:0]    w_n;
   logic [CW-1:0] w_n_ext;
   logic [CW:0]   w_free;
   logic          w_enq;
   logic [31:0]   w_fpc_inc;
   logic [31:0]   w_fpc_next;
   logic [31:0]   w_redir_fpc;
   logic [PW-1:0] w_head1;
   logic          w_unused;

   // Byte-offset bits of the redirect target carry no information.
   assign w_unused = ^redirect_target[1:0];

   // Dequeue clamp, enqueue admission and next fetch PC.
   always_comb begin
      w_deq_req   = (deq_count == 2'd3) ? 2'd2 : deq_count;
      w_deq       = ({{(CW-2){1'b0}}, w_deq_req} > r_count) ? r_count
                                                            : {{(CW-2){1'b0}}, w_deq_req};
      w_n         = r_skip ? 2'd1 : 2'd2;
      w_n_ext     = {{(CW-2){1'b0}}, w_n};
      // Space released by this cycle's dequeue is usable by this cycle's fetch.
      w_free      = L_QDEPTH - {1'b0, r_count} + {1'b0, w_deq};
      w_enq       = (w_free >= {1'b0, w_n_ext});
      w_fpc_inc   = r_fpc + 32'd8;
      w_fpc_next  = (w_fpc_inc >= L_RANGE) ? (w_fpc_inc - L_RANGE) : w_fpc_inc;
      w_redir_fpc = {redirect_target[31:3], 3'b000} % L_RANGE;
      w_head1     = r_head + L_ONE;
   end

   // Control state: pointers, occupancy, fetch PC and mid-pair skip flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_fpc   <= RESET_PC;
         r_skip  <= 1'b0;
      end else if (redirect_valid) begin
         r_head  <= r_tail;
         r_count <= '0;
         r_fpc   <= w_redir_fpc;
         r_skip  <= redirect_target[2];
      end else begin
         r_head  <= r_head + w_deq[PW-1:0];
         r_count <= r_count - w_deq + (w_enq ? w_n_ext : '0);
         if (w_enq) begin
            r_tail <= r_tail + (r_skip ? L_ONE : L_TWO);
            r_fpc  <= w_fpc_next;
            r_skip <= 1'b0;
         end
      end
   end

   // Queue storage; contents beyond the valid window are never observed.
   always_ff @(posedge clk) begin
      if (!redirect_valid && w_enq) begin
         if (r_skip) begin
            r_instr[r_tail] <= imem_instr2;
            r_pc[r_tail]    <= r_fpc + 32'd4;
         end else begin
            r_instr[r_tail]         <= imem_instr1;
            r_pc[r_tail]            <= r_fpc;
            r_instr[r_tail + L_ONE] <= imem_instr2;
            r_pc[r_tail + L_ONE]    <= r_fpc + 32'd4;
         end
      end
   end

   // Head-of-queue view for decode; empty slots read as zero.
   always_comb begin
      imem_addr  = r_fpc;
      q_count    = r_count;
      out_valid0 = (r_count != '0);
      out_valid1 = (r_count >= CW'(2));
      out_instr0 = out_valid0 ? r_instr[r_head]  : '0;
      out_pc0    = out_valid0 ? r_pc[r_head]     : '0;
      out_instr1 = out_valid1 ? r_instr[w_head1] : '0;
      out_pc1    = out_valid1 ? r_pc[w_head1]    : '0;
   end

endmodule

// File: tb/tb_dual_fetch_controller.sv
// Directed bench for dual_fetch_controller with a combinational memory model.
module tb_dual_fetch_controller;

   logic        clk;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr1;
   logic [31:0] imem_instr2;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [1:0]  deq_count;
   logic        out_valid0;
   logic [31:0] out_instr0;
   logic [31:0] out_pc0;
   logic        out_valid1;
   logic [31:0] out_instr1;
   logic [31:0] out_pc1;
   logic [2:0]  q_count;

   int n_checks = 0;
   int n_fails  = 0;

   dual_fetch_controller #(
      .QDEPTH     (4),
      .IMEM_WORDS (128),
      .RESET_PC   (32'h0000_0000)
   ) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_addr       (imem_addr),
      .imem_instr1     (imem_instr1),
      .imem_instr2     (imem_instr2),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .deq_count       (deq_count),
      .out_valid0      (out_valid0),
      .out_instr0      (out_instr0),
      .out_pc0         (out_pc0),
      .out_valid1      (out_valid1),
      .out_instr1      (out_instr1),
      .out_pc1         (out_pc1),
      .q_count         (q_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory word at byte address a is tagged with its own address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hC0DE_0000 ^ a;
   endfunction

   assign imem_instr1 = mem_word(imem_addr);
   assign imem_instr2 = mem_word(imem_addr + 32'd4);

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n           = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = 32'h0;
      deq_count       = 2'd0;
      #12;
      check_eq("rst_count", 32'(q_count), 32'd0);
      check_eq("rst_valid0", 32'(out_valid0), 32'd0);
      check_eq("rst_valid1", 32'(out_valid1), 32'd0);
      check_eq("rst_instr0", out_instr0, 32'h0);
      check_eq("rst_pc1", out_pc1, 32'h0);
      check_eq("rst_addr", imem_addr, 32'h0);
      rst_n = 1'b1;

      // Fill with no dequeue
      step();
      check_eq("fill1_count", 32'(q_count), 32'd2);
      check_eq("fill1_pc0", out_pc0, 32'h0);
      check_eq("fill1_pc1", out_pc1, 32'h4);
      check_eq("fill1_instr0", out_instr0, 32'hC0DE_0000);
      check_eq("fill1_instr1", out_instr1, 32'hC0DE_0004);
      check_eq("fill1_addr", imem_addr, 32'h8);
      step();
      check_eq("fill2_count", 32'(q_count), 32'd4);
      check_eq("fill2_addr", imem_addr, 32'h10);
      step();
      check_eq("stall_count", 32'(q_count), 32'd4);
      check_eq("stall_addr", imem_addr, 32'h10);
      check_eq("stall_pc0", out_pc0, 32'h0);

      // Full queue, single dequeue frees only one slot
      deq_count = 2'd1;
      step();
      check_eq("deq1a_count", 32'(q_count), 32'd3);
      check_eq("deq1a_pc0", out_pc0, 32'h4);
      check_eq("deq1a_addr", imem_addr, 32'h10);
      step();
      check_eq("deq1b_count", 32'(q_count), 32'd4);
      check_eq("deq1b_pc0", out_pc0, 32'h8);
      check_eq("deq1b_pc1", out_pc1, 32'hC);
      check_eq("deq1b_addr", imem_addr, 32'h18);

      // Redirect to a mid-pair target while full
      deq_count       = 2'd2;
      redirect_valid  = 1'b1;
      redirect_target = 32'h0000_002E;
      #1;
      check_eq("redir_preflush_pc0", out_pc0, 32'h8);
      check_eq("redir_preflush_cnt", 32'(q_count), 32'd4);
      step();
      redirect_valid = 1'b0;
      deq_count      = 2'd0;
      check_eq("redir_flush_count", 32'(q_count), 32'd0);
      check_eq("redir_flush_valid0", 32'(out_valid0), 32'd0);
      check_eq("redir_flush_addr", imem_addr, 32'h28);
      step();
      check_eq("redir_skip_count", 32'(q_count), 32'd1);
      check_eq("redir_skip_pc0", out_pc0, 32'h2C);
      check_eq("redir_skip_instr0", out_instr0, 32'hC0DE_002C);
      check_eq("redir_skip_valid1", 32'(out_valid1), 32'd0);
      check_eq("redir_skip_pc1", out_pc1, 32'h0);
      check_eq("redir_skip_addr", imem_addr, 32'h30);
      // Over-request with one entry: no underflow
      deq_count = 2'd2;
      step();
      check_eq("overreq_count", 32'(q_count), 32'd2);
      check_eq("overreq_pc0", out_pc0, 32'h30);
      check_eq("overreq_pc1", out_pc1, 32'h34);
      check_eq("overreq_addr", imem_addr, 32'h38);

      // Aligned redirect
      deq_count       = 2'd0;
      redirect_valid  = 1'b1;
      redirect_target = 32'h0000_0028;
      step();
      redirect_valid = 1'b0;
      check_eq("redir_al_count", 32'(q_count), 32'd0);
      step();
      check_eq("redir_al_pc0", out_pc0, 32'h28);
      check_eq("redir_al_pc1", out_pc1, 32'h2C);
      check_eq("redir_al_addr", imem_addr, 32'h30);

      // Steady state two per cycle, including deq_count=3 treated as 2
      for (int i = 0; i < 3; i++) begin
         deq_count = (i == 1) ? 2'd3 : 2'd2;
         step();
         check_eq($sformatf("steady%0d_pc0", i), out_pc0, 32'h30 + 32'(i * 8));
         check_eq($sformatf("steady%0d_count", i), 32'(q_count), 32'd2);
      end

      // Address wrap
      deq_count       = 2'd2;
      redirect_valid  = 1'b1;
      redirect_target = 32'h0000_01F8;
      step();
      redirect_valid = 1'b0;
      check_eq("wrap_addr0", imem_addr, 32'h1F8);
      step();
      check_eq("wrap_pc0", out_pc0, 32'h1F8);
      check_eq("wrap_pc1", out_pc1, 32'h1FC);
      check_eq("wrap_instr1", out_instr1, 32'hC0DE_01FC);
      check_eq("wrap_addr1", imem_addr, 32'h0);
      step();
      check_eq("wrap2_pc0", out_pc0, 32'h0);
      check_eq("wrap2_count", 32'(q_count), 32'd2);
      check_eq("wrap2_addr", imem_addr, 32'h8);

      // Asynchronous reset mid-run
      rst_n = 1'b0;
      #1;
      check_eq("mrst_valid0", 32'(out_valid0), 32'd0);
      check_eq("mrst_count", 32'(q_count), 32'd0);
      check_eq("mrst_pc0", out_pc0, 32'h0);
      check_eq("mrst_addr", imem_addr, 32'h0);
      #1;
      rst_n = 1'b1;

      // deq_count=2 from reset
      step();
      check_eq("post_pc0_a", out_pc0, 32'h0);
      check_eq("post_valid1_a", 32'(out_valid1), 32'd1);
      step();
      check_eq("post_pc0_b", out_pc0, 32'h8);
      step();
      check_eq("post_pc0_c", out_pc0, 32'h10);
      check_eq("post_count_c", 32'(q_count), 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
